// File: rtl/dcache_pkg.sv
// Shared types and defaults for the dcache control slice.
package dcache_pkg;

  localparam int DCACHE_INDEX_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    CHECK,
    WB,
    CLEAR,
    DONE
  } flush_state_t;

endpackage

// File: rtl/dcache_bit_altram.sv
// 1-bit-wide dirty array: one read port with 1-cycle latency, one write port,
// and same-cycle write-to-read forwarding.
module dcache_bit_altram #(
  parameter int INDEX_BITS = 8
) (
  input  logic                  clock,
  input  logic                  rden,
  input  logic [INDEX_BITS-1:0] rdaddress,
  input  logic                  wren,
  input  logic [INDEX_BITS-1:0] wraddress,
  input  logic                  data,
  output logic                  q
);

  localparam int DEPTH = 2 ** INDEX_BITS;

  logic mem [DEPTH];

  always_ff @(posedge clock) begin
    if (wren) mem[wraddress] <= data;
    if (rden) q <= (wren && wraddress == rdaddress) ? data : mem[rdaddress];
  end

endmodule

// File: rtl/dcache_flush_ctrl.sv
// Dirty-bit array port arbiter: pipeline passthrough when idle, otherwise a
// flush walker that writes back and clears every dirty line.
module dcache_flush_ctrl
  import dcache_pkg::*;
#(
  parameter int INDEX_BITS = DCACHE_INDEX_BITS
) (
  input  logic                  clock,
  input  logic                  aclr,
  input  logic                  flush_req,
  output logic                  flush_busy,
  output logic                  flush_done,
  output logic                  pipe_stall,
  input  logic                  pipe_rden,
  input  logic [INDEX_BITS-1:0] pipe_rdaddress,
  input  logic                  pipe_wren,
  input  logic [INDEX_BITS-1:0] pipe_wraddress,
  input  logic                  pipe_wdata,
  output logic                  bit_rden,
  output logic [INDEX_BITS-1:0] bit_rdaddress,
  output logic                  bit_wren,
  output logic [INDEX_BITS-1:0] bit_wraddress,
  output logic                  bit_wdata,
  input  logic                  bit_q,
  output logic                  wb_req,
  output logic [INDEX_BITS-1:0] wb_index,
  input  logic                  wb_ack
);

  localparam logic [INDEX_BITS-1:0] LAST_IDX = '1;

  flush_state_t          state;
  logic [INDEX_BITS-1:0] idx;
  logic                  idle;

  always_ff @(posedge clock) begin
    if (aclr) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      case (state)
        IDLE: if (flush_req) begin
          state <= READ;
          idx   <= '0;
        end
        READ: state <= CHECK;
        CHECK: begin
          if (bit_q)                state <= WB;
          else if (idx == LAST_IDX) state <= DONE;
          else begin
            idx   <= idx + INDEX_BITS'(1);
            state <= READ;
          end
        end
        WB: if (wb_ack) state <= CLEAR;
        CLEAR: begin
          if (idx == LAST_IDX) state <= DONE;
          else begin
            idx   <= idx + INDEX_BITS'(1);
            state <= READ;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outside IDLE every array strobe comes from state alone, so wb_ack never
  // reaches the array ports combinationally.
  always_comb begin
    idle          = (state == IDLE);
    flush_busy    = !idle;
    pipe_stall    = !idle;
    flush_done    = (state == DONE);
    wb_req        = (state == WB);
    wb_index      = idx;
    bit_rden      = idle ? pipe_rden      : (state == READ);
    bit_rdaddress = idle ? pipe_rdaddress : idx;
    bit_wren      = idle ? pipe_wren      : (state == CLEAR);
    bit_wraddress = idle ? pipe_wraddress : idx;
    bit_wdata     = idle & pipe_wdata;
  end

endmodule

// File: tb/tb_dcache_flush_ctrl.sv
// Bench for dcache_flush_ctrl with a real dirty array behind it, INDEX_BITS=3.
module tb_dcache_flush_ctrl;

  localparam int IB = 3;
  localparam int N  = 2 ** IB;

  logic          clock = 1'b0;
  logic          aclr = 1'b1;
  logic          flush_req = 1'b0;
  logic          flush_busy, flush_done, pipe_stall;
  logic          pipe_rden = 1'b0, pipe_wren = 1'b0, pipe_wdata = 1'b0;
  logic [IB-1:0] pipe_rdaddress = '0, pipe_wraddress = '0;
  logic          bit_rden, bit_wren, bit_wdata, bit_q;
  logic [IB-1:0] bit_rdaddress, bit_wraddress;
  logic          wb_req;
  logic [IB-1:0] wb_index;
  logic          wb_ack = 1'b0;

  int checks = 0;
  int failures = 0;
  bit ref_mem [N];
  int ack_dly [N];

  always #5 clock = ~clock;

  dcache_flush_ctrl #(.INDEX_BITS(IB)) dut (
    .clock(clock), .aclr(aclr), .flush_req(flush_req),
    .flush_busy(flush_busy), .flush_done(flush_done), .pipe_stall(pipe_stall),
    .pipe_rden(pipe_rden), .pipe_rdaddress(pipe_rdaddress),
    .pipe_wren(pipe_wren), .pipe_wraddress(pipe_wraddress), .pipe_wdata(pipe_wdata),
    .bit_rden(bit_rden), .bit_rdaddress(bit_rdaddress),
    .bit_wren(bit_wren), .bit_wraddress(bit_wraddress), .bit_wdata(bit_wdata),
    .bit_q(bit_q), .wb_req(wb_req), .wb_index(wb_index), .wb_ack(wb_ack)
  );

  dcache_bit_altram #(.INDEX_BITS(IB)) u_ram (
    .clock(clock), .rden(bit_rden), .rdaddress(bit_rdaddress),
    .wren(bit_wren), .wraddress(bit_wraddress), .data(bit_wdata), .q(bit_q)
  );

  typedef struct {
    logic          wr;
    logic [IB-1:0] wa;
    logic          wd;
    logic          rd;
    logic [IB-1:0] ra;
    logic          exp_q;
  } vec_t;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  task automatic write_pipe(input int i, input bit v);
    pipe_wren = 1'b1; pipe_wraddress = IB'(i); pipe_wdata = v;
    tick();
    pipe_wren = 1'b0; pipe_wdata = 1'b0;
    ref_mem[i] = v;
  endtask

  task automatic read_check(input string name, input int i);
    pipe_rden = 1'b1; pipe_rdaddress = IB'(i);
    tick();
    pipe_rden = 1'b0;
    chk(name, int'(bit_q), int'(ref_mem[i]));
  endtask

  // Expected behaviour from the walk rules: dirty lines written back in
  // ascending order, 2 cycles per index plus DONE, plus (wait+2) per dirty line.
  task automatic run_flush(input bit race, input bit noise);
    int exp_q[$];
    int got_q[$];
    int exp_cyc, busy_cyc, done_cnt, done_at, wait_cnt, bad_wr, bad_hold, clears, acked_idx;
    bit acked, fin;
    logic [IB-1:0] hold;
    busy_cyc = 0; done_cnt = 0; done_at = 0; wait_cnt = 0; bad_wr = 0;
    bad_hold = 0; clears = 0; acked_idx = 0; acked = 1'b0; fin = 1'b0; hold = '0;
    flush_req = 1'b1;
    if (race) begin
      pipe_wren = 1'b1; pipe_wraddress = '0; pipe_wdata = 1'b1;
      ref_mem[0] = 1'b1;
    end
    exp_cyc = 2 * N + 1;
    for (int i = 0; i < N; i++)
      if (ref_mem[i]) begin
        exp_q.push_back(i);
        exp_cyc += ack_dly[i] + 2;
      end
    tick();
    flush_req = 1'b0; pipe_wren = 1'b0; pipe_wdata = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      if (!flush_busy) begin
        fin = 1'b1;
        break;
      end
      busy_cyc++;
      if (flush_done) begin
        done_cnt++;
        done_at = busy_cyc;
      end
      if (bit_wren) begin
        if (acked && !bit_wdata && int'(bit_wraddress) == acked_idx) begin
          clears++;
          acked = 1'b0;
        end else bad_wr++;
      end
      if (wb_req) begin
        if (wait_cnt == 0) begin
          got_q.push_back(int'(wb_index));
          hold = wb_index;
        end else if (wb_index !== hold) bad_hold++;
        wb_ack = (wait_cnt == ack_dly[wb_index]);
        if (wb_ack) begin
          acked = 1'b1;
          acked_idx = int'(wb_index);
        end
        wait_cnt++;
      end else begin
        wait_cnt = 0;
        wb_ack = noise ? 1'($urandom_range(1)) : 1'b0;
      end
      if (noise) begin
        flush_req      = 1'($urandom_range(1));
        pipe_wren      = 1'($urandom_range(1));
        pipe_wraddress = IB'($urandom_range(N - 1));
        pipe_wdata     = 1'($urandom_range(1));
        pipe_rden      = 1'($urandom_range(1));
        pipe_rdaddress = IB'($urandom_range(N - 1));
      end
      tick();
    end
    flush_req = 1'b0; wb_ack = 1'b0; pipe_wren = 1'b0; pipe_rden = 1'b0; pipe_wdata = 1'b0;
    chk("flush_finished", int'(fin), 1);
    chk("busy_cycles", busy_cyc, exp_cyc);
    chk("done_pulses", done_cnt, 1);
    chk("done_on_last_busy_cycle", done_at, exp_cyc);
    chk("wb_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      chk("wb_order", (i < got_q.size()) ? got_q[i] : -1, exp_q[i]);
    chk("stray_array_writes", bad_wr, 0);
    chk("wb_index_unstable", bad_hold, 0);
    chk("clears_after_ack", clears, exp_q.size());
    for (int i = 0; i < N; i++) ref_mem[i] = 1'b0;
    tick();
    chk("req_not_queued", int'(flush_busy), 0);
    for (int i = 0; i < N; i++) read_check("post_flush_clean", i);
  endtask

  initial begin
    vec_t tbl [7];
    bit   seen;
    tbl[0] = '{1'b1, 3'd5, 1'b1, 1'b0, 3'd0, 1'b0};
    tbl[1] = '{1'b0, 3'd0, 1'b0, 1'b1, 3'd5, 1'b1};
    tbl[2] = '{1'b1, 3'd2, 1'b1, 1'b1, 3'd2, 1'b1};
    tbl[3] = '{1'b1, 3'd5, 1'b0, 1'b1, 3'd5, 1'b0};
    tbl[4] = '{1'b0, 3'd0, 1'b0, 1'b1, 3'd2, 1'b1};
    tbl[5] = '{1'b0, 3'd0, 1'b0, 1'b1, 3'd5, 1'b0};
    tbl[6] = '{1'b1, 3'd2, 1'b0, 1'b1, 3'd3, 1'b0};
    for (int i = 0; i < N; i++) ack_dly[i] = 0;

    // Reset state
    tick(); tick();
    chk("rst_busy", int'(flush_busy), 0);
    chk("rst_done", int'(flush_done), 0);
    chk("rst_wb_req", int'(wb_req), 0);
    aclr = 1'b0;
    chk("rst_stall", int'(pipe_stall), 0);
    for (int i = 0; i < N; i++) write_pipe(i, 1'b0);

    // Passthrough vectors
    for (int v = 0; v < 7; v++) begin
      pipe_wren = tbl[v].wr; pipe_wraddress = tbl[v].wa; pipe_wdata = tbl[v].wd;
      pipe_rden = tbl[v].rd; pipe_rdaddress = tbl[v].ra;
      #1;
      chk("pt_stall", int'(pipe_stall), 0);
      chk("pt_wren", int'(bit_wren), int'(tbl[v].wr));
      chk("pt_wraddr", int'(bit_wraddress), int'(tbl[v].wa));
      chk("pt_rdaddr", int'(bit_rdaddress), int'(tbl[v].ra));
      tick();
      if (tbl[v].wr) ref_mem[tbl[v].wa] = tbl[v].wd;
      if (tbl[v].rd) chk("pt_q", int'(bit_q), int'(tbl[v].exp_q));
    end
    pipe_wren = 1'b0; pipe_rden = 1'b0; pipe_wdata = 1'b0;

    // All-clean flush
    run_flush(1'b0, 1'b0);

    // Dirty 2 and 7, immediate ack
    write_pipe(2, 1'b1); write_pipe(7, 1'b1);
    run_flush(1'b0, 1'b0);

    // Delayed ack on 3, with flush_req/pipe/ack noise while busy
    write_pipe(3, 1'b1);
    ack_dly[3] = 4;
    run_flush(1'b0, 1'b1);
    ack_dly[3] = 0;

    // Pipe write to idx0 in the flush_req cycle
    run_flush(1'b1, 1'b1);

    // Reset while waiting on the writeback for idx4
    write_pipe(1, 1'b1); write_pipe(4, 1'b1); write_pipe(6, 1'b1);
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (wb_req && wb_index == 3'd4) begin
        seen = 1'b1;
        break;
      end
      wb_ack = wb_req;
      tick();
    end
    wb_ack = 1'b0;
    chk("reach_wb4", int'(seen), 1);
    aclr = 1'b1;
    tick();
    aclr = 1'b0;
    chk("mid_rst_wb_req", int'(wb_req), 0);
    chk("mid_rst_busy", int'(flush_busy), 0);
    chk("mid_rst_done", int'(flush_done), 0);
    seen = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (flush_done || flush_busy) seen = 1'b1;
    end
    chk("mid_rst_quiet", int'(seen), 0);
    ref_mem[1] = 1'b0;
    for (int i = 0; i < N; i++) read_check("mid_rst_bits", i);
    run_flush(1'b0, 1'b0);

    // Randomized dirty patterns and ack delays
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < N; i++) begin
        write_pipe(i, 1'($urandom_range(1)));
        ack_dly[i] = int'($urandom_range(3));
      end
      run_flush(1'($urandom_range(1)), 1'(r % 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
